// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running x/y pixel counters with sync/data-enable decode,
// a programmable pixel-tick delay on hsync/vsync/de, and line/frame start pulses.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned DELAY    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_en,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic       o_line_start,
  output logic       o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_x_last;
  logic       w_y_last;
  logic       w_active;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [2:0] w_decode;
  logic [2:0] w_dly_out;

  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (i_pix_en) begin
        if (w_x_last) begin
          r_x           <= '0;
          r_y           <= w_y_last ? 10'd0 : r_y + 10'd1;
          r_line_start  <= 1'b1;
          r_frame_start <= w_y_last;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  assign w_active = (r_x < H_ACT) && (r_y < V_ACT);
  assign w_hs_raw = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
  assign w_vs_raw = (r_y >= VS_FIRST) && (r_y <= VS_LAST);
  assign w_decode = {w_hs_raw, w_vs_raw, w_active};

  // Stage contents are the raw (true-when-asserted) decode; polarity is applied at the pins.
  if (DELAY == 0) begin : g_no_delay
    assign w_dly_out = w_decode;
  end else begin : g_delay
    logic [2:0] r_dly [DELAY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < int'(DELAY); i++) r_dly[i] <= 3'b000;
      end else if (i_pix_en) begin
        r_dly[0] <= w_decode;
        for (int i = 1; i < int'(DELAY); i++) r_dly[i] <= r_dly[i-1];
      end
    end

    assign w_dly_out = r_dly[DELAY-1];
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_active      = w_active;
  assign o_hsync       = w_dly_out[2] ? SYNC_POL : ~SYNC_POL;
  assign o_vsync       = w_dly_out[1] ? SYNC_POL : ~SYNC_POL;
  assign o_de          = w_dly_out[0];
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four builds (default, DELAY=0/SYNC_POL=1, DELAY=3, small raster)
// checked every cycle against a tick-count arithmetic model.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic pix_en;

  logic [9:0] x    [4];
  logic [9:0] y    [4];
  logic       act  [4];
  logic       hs   [4];
  logic       vs   [4];
  logic       de   [4];
  logic       ls   [4];
  logic       fs   [4];
  logic [25:0] got [4];

  longint t;        // pix_en ticks since reset release
  bit     last_pe;  // previous edge advanced the counters
  int     n_checks;
  int     n_err;

  vga_timing_gen u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(x[0]), .o_y(y[0]),
    .o_active(act[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_de(de[0]),
    .o_line_start(ls[0]), .o_frame_start(fs[0])
  );

  vga_timing_gen #(.SYNC_POL(1'b1), .DELAY(0)) u_dut_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(x[1]), .o_y(y[1]),
    .o_active(act[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_de(de[1]),
    .o_line_start(ls[1]), .o_frame_start(fs[1])
  );

  vga_timing_gen #(.DELAY(3)) u_dut_d3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(x[2]), .o_y(y[2]),
    .o_active(act[2]), .o_hsync(hs[2]), .o_vsync(vs[2]), .o_de(de[2]),
    .o_line_start(ls[2]), .o_frame_start(fs[2])
  );

  // 16 x 11 raster so whole frames fit in a short run.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .DELAY(2)
  ) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(x[3]), .o_y(y[3]),
    .o_active(act[3]), .o_hsync(hs[3]), .o_vsync(vs[3]), .o_de(de[3]),
    .o_line_start(ls[3]), .o_frame_start(fs[3])
  );

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign got[g] = {x[g], y[g], act[g], hs[g], vs[g], de[g], ls[g], fs[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after tc ticks: position is tc split into line/frame, delayed
  // outputs are the decode of tick tc-d (inactive before the pipeline has filled).
  function automatic logic [25:0] model(longint tc, bit pe_last, int ha, int hf, int hsw,
                                        int hb, int va, int vf, int vsw, int vb, bit pol, int d);
    longint ht = ha + hf + hsw + hb;
    longint vt = va + vf + vsw + vb;
    longint px = tc % ht;
    longint py = (tc / ht) % vt;
    bit a  = (px < ha) && (py < va);
    bit hr = 1'b0;
    bit vr = 1'b0;
    bit e  = 1'b0;
    bit l  = pe_last && (tc > 0) && (px == 0);
    bit f  = l && (py == 0);
    if (tc >= d) begin
      longint xd = (tc - d) % ht;
      longint yd = ((tc - d) / ht) % vt;
      hr = (xd >= ha + hf) && (xd < ha + hf + hsw);
      vr = (yd >= va + vf) && (yd < va + vf + vsw);
      e  = (xd < ha) && (yd < va);
    end
    return {10'(px), 10'(py), a, hr ? pol : ~pol, vr ? pol : ~pol, e, l, f};
  endfunction

  function automatic logic [25:0] exp_of(int k);
    case (k)
      0:       return model(t, last_pe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1);
      1:       return model(t, last_pe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 0);
      2:       return model(t, last_pe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 3);
      default: return model(t, last_pe, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 2);
    endcase
  endfunction

  // Drives one clock of stimulus and advances the model; samples settle 1 time unit later.
  task automatic tick(input bit pe);
    pix_en = pe;
    @(posedge clk);
    if (rst_n) begin
      last_pe = pe;
      if (pe) t++;
    end else begin
      last_pe = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    t = 0;
    last_pe = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL reset dut%0d got=%h exp=%h", k, got[k], exp_of(k));
        end
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL reset_release dut%0d t=%0d got=%h exp=%h", k, t, got[k], exp_of(k));
        end
      end
    end
  endtask

  task automatic test_line;
    int hs_low = 0;
    int n_ls = 0;
    while (t < 1600) begin
      tick(1'b1);
      if (t <= 800 && hs[0] == 1'b0) hs_low++;
      if (ls[0]) n_ls++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL line dut%0d t=%0d got=%h exp=%h", k, t, got[k], exp_of(k));
        end
      end
    end
    n_checks++;
    if (hs_low !== 96) begin
      n_err++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    n_checks++;
    if (n_ls !== 2) begin
      n_err++;
      $display("FAIL line_start_count got=%0d exp=2", n_ls);
    end
  endtask

  task automatic test_frame;
    int n_fs = 0;
    int n_de = 0;
    int cyc = 0;
    rst_n = 1'b0;
    tick(1'b0);
    t = 0;
    rst_n = 1'b1;
    while (t < 528 && cyc < 5000) begin
      tick(($urandom % 4) != 0);
      cyc++;
      if (fs[3]) n_fs++;
      if (last_pe && de[3]) n_de++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL frame dut%0d t=%0d got=%h exp=%h", k, t, got[k], exp_of(k));
        end
      end
    end
    n_checks++;
    if (t !== 528) begin
      n_err++;
      $display("FAIL frame_budget got_ticks=%0d exp=528", t);
    end
    n_checks++;
    if (n_fs !== 3) begin
      n_err++;
      $display("FAIL frame_start_count got=%0d exp=3", n_fs);
    end
    n_checks++;
    if (n_de !== 144) begin
      n_err++;
      $display("FAIL de_count got=%0d exp=144", n_de);
    end
  endtask

  task automatic test_toggle;
    bit prev_ls = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick(c[0] == 1'b0);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL toggle dut%0d t=%0d got=%h exp=%h", k, t, got[k], exp_of(k));
        end
      end
      n_checks++;
      if (prev_ls && ls[3]) begin
        n_err++;
        $display("FAIL toggle_pulse_width t=%0d got=11 exp=10", t);
      end
      prev_ls = ls[3];
    end
  endtask

  task automatic test_mid_reset;
    int n_fs_small = 0;
    int n_fs_main = 0;
    int cyc = 0;
    while (!(t % 800 == 300 && t >= 800) && cyc < 5000) begin
      tick(1'b1);
      cyc++;
    end
    n_checks++;
    if (x[0] !== 10'd300) begin
      n_err++;
      $display("FAIL mid_reset_position got=%0d exp=300", x[0]);
    end
    #2;
    rst_n = 1'b0;
    t = 0;
    last_pe = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp_of(k)) begin
        n_err++;
        $display("FAIL async_reset dut%0d got=%h exp=%h", k, got[k], exp_of(k));
      end
    end
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 180; c++) begin
      tick(1'b1);
      if (fs[3]) n_fs_small++;
      if (fs[0]) n_fs_main++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL after_reset dut%0d t=%0d got=%h exp=%h", k, t, got[k], exp_of(k));
        end
      end
    end
    n_checks++;
    if (n_fs_small !== 1 || n_fs_main !== 0) begin
      n_err++;
      $display("FAIL restart_frame_start got=%0d/%0d exp=1/0", n_fs_small, n_fs_main);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      tick(1'($urandom));
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp_of(k)) begin
          n_err++;
          $display("FAIL random dut%0d t=%0d got=%h exp=%h", k, t, got[k], exp_of(k));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    pix_en = 1'b0;
    rst_n = 1'b0;
    t = 0;
    last_pe = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_toggle();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
